// File: rtl/lr_shift_reg.sv
// rtl/lr_shift_reg.sv - bidirectional shift register with parallel load and serial in/out
//
// Purpose: generic data-path shifter / serialiser. Each rising edge performs, in
// priority order, a parallel load, a one-bit shift (direction from lr_bar), or a hold.
//
// Optional feature: define LR_SHIFT_ROTATE_EN to add the rot input, which makes a
// shift refill the vacated position with the bit leaving the register instead of ser_in.
//
// Ports:
//   clk      - rising-edge clock
//   rst      - asynchronous active-low reset, clears y
//   load     - parallel load enable (highest priority)
//   shift_en - shift enable, ignored while load=1
//   lr_bar   - 0 = shift toward MSB, 1 = shift toward LSB
//   i        - parallel load data
//   ser_in   - serial fill bit for the vacated position
//   rot      - (LR_SHIFT_ROTATE_EN only) refill from the outgoing bit
//   y        - registered contents
//   ser_out  - bit that leaves on the next shift in the current direction

module lr_shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift_en,
    input  logic             lr_bar,
    input  logic [WIDTH-1:0] i,
    input  logic             ser_in,
`ifdef LR_SHIFT_ROTATE_EN
    input  logic             rot,
`endif
    output logic [WIDTH-1:0] y,
    output logic             ser_out
);

    logic fill_bit;

    // The outgoing bit is ser_out in both directions, so rotation reuses it.
`ifdef LR_SHIFT_ROTATE_EN
    assign fill_bit = rot ? ser_out : ser_in;
`else
    assign fill_bit = ser_in;
`endif

    assign ser_out = lr_bar ? y[0] : y[WIDTH-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            y <= '0;
        end else if (load) begin
            y <= i;
        end else if (shift_en) begin
            if (lr_bar) begin
                y <= {fill_bit, y[WIDTH-1:1]};
            end else begin
                y <= {y[WIDTH-2:0], fill_bit};
            end
        end
    end

endmodule

// File: tb/tb_lr_shift_reg.sv
// tb/tb_lr_shift_reg.sv - directed self-checking bench for lr_shift_reg

module tb_lr_shift_reg;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             load;
    logic             shift_en;
    logic             lr_bar;
    logic [WIDTH-1:0] i;
    logic             ser_in;
`ifdef LR_SHIFT_ROTATE_EN
    logic             rot;
`endif
    logic [WIDTH-1:0] y;
    logic             ser_out;

    int checks = 0;
    int errors = 0;

    lr_shift_reg #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .shift_en (shift_en),
        .lr_bar   (lr_bar),
        .i        (i),
        .ser_in   (ser_in),
`ifdef LR_SHIFT_ROTATE_EN
        .rot      (rot),
`endif
        .y        (y),
        .ser_out  (ser_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_y(input string tag, input logic [WIDTH-1:0] exp);
        checks++;
        assert (y === exp) else begin
            errors++;
            $error("FAIL %s: y observed %b expected %b", tag, y, exp);
        end
    endtask

    task automatic chk_so(input string tag, input logic exp);
        checks++;
        assert (ser_out === exp) else begin
            errors++;
            $error("FAIL %s: ser_out observed %b expected %b", tag, ser_out, exp);
        end
    endtask

    // Apply inputs after the falling edge, then wait for the rising edge plus 1.
    task automatic step(input logic ld, input logic se, input logic lr,
                        input logic [WIDTH-1:0] d, input logic si);
        @(negedge clk);
        load = ld; shift_en = se; lr_bar = lr; i = d; ser_in = si;
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [WIDTH-1:0] d);
        step(1'b1, 1'b0, 1'b0, d, 1'b0);
    endtask

    initial begin
        rst = 1'b0; load = 1'b0; shift_en = 1'b0; lr_bar = 1'b0;
        i = '0; ser_in = 1'b0;
`ifdef LR_SHIFT_ROTATE_EN
        rot = 1'b0;
`endif
        #12;
        chk_y("reset_initial", 4'b0000);
        @(negedge clk);
        rst = 1'b1;

        // Asynchronous reset without a clock edge
        do_load(4'b1011);
        chk_y("load_1011", 4'b1011);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk_y("async_reset_no_edge", 4'b0000);
        load = 1'b1; i = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        chk_y("reset_holds_through_edges", 4'b0000);
        @(negedge clk);
        rst = 1'b1; load = 1'b0;

        // Load then left shift
        do_load(4'b0100);
        chk_so("left_ser_out_before", 1'b0);
        step(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
        chk_y("left_shift", 4'b1000);
        chk_so("left_ser_out_after", 1'b1);

        // Load then right shift twice
        do_load(4'b0100);
        step(1'b0, 1'b1, 1'b1, 4'b0000, 1'b0);
        chk_y("right_shift_1", 4'b0010);
        step(1'b0, 1'b1, 1'b1, 4'b0000, 1'b0);
        chk_y("right_shift_2", 4'b0001);
        chk_so("right_ser_out", 1'b1);
        lr_bar = 1'b0;
        #1;
        chk_so("ser_out_dir_comb", 1'b0);

        // Load priority over shift
        step(1'b1, 1'b1, 1'b1, 4'b1010, 1'b1);
        chk_y("load_priority", 4'b1010);

        // Hold for three cycles
        step(1'b0, 1'b0, 1'b0, 4'b0101, 1'b1);
        step(1'b0, 1'b0, 1'b1, 4'b0101, 1'b1);
        step(1'b0, 1'b0, 1'b0, 4'b0101, 1'b0);
        chk_y("hold_3_cycles", 4'b1010);

        // Serial fill left 1,0,1,1 from zero, then one right shift
        do_load(4'b0000);
        step(1'b0, 1'b1, 1'b0, 4'b0000, 1'b1);
        step(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
        step(1'b0, 1'b1, 1'b0, 4'b0000, 1'b1);
        step(1'b0, 1'b1, 1'b0, 4'b0000, 1'b1);
        chk_y("serial_fill_left", 4'b1011);
        step(1'b0, 1'b1, 1'b1, 4'b0000, 1'b0);
        chk_y("toggle_right", 4'b0101);

        // Right shift fill with ser_in=1 (MSB insertion)
        step(1'b0, 1'b1, 1'b1, 4'b0000, 1'b1);
        chk_y("right_fill_one", 4'b1010);
        step(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
        chk_y("left_discard_msb", 4'b0100);

`ifdef LR_SHIFT_ROTATE_EN
        rot = 1'b1;
        do_load(4'b1001);
        step(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
        chk_y("rotate_left", 4'b0011);
        do_load(4'b1001);
        step(1'b0, 1'b1, 1'b1, 4'b0000, 1'b0);
        chk_y("rotate_right", 4'b1100);
        step(1'b1, 1'b1, 1'b1, 4'b0110, 1'b0);
        chk_y("load_over_rotate", 4'b0110);
        rot = 1'b0;
`endif

        // Reset mid-shift-sequence, then release
        do_load(4'b1111);
        step(1'b0, 1'b1, 1'b0, 4'b0000, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk_y("reset_mid_sequence", 4'b0000);
        @(negedge clk);
        rst = 1'b1; load = 1'b0; shift_en = 1'b0;
        @(posedge clk);
        #1;
        chk_y("after_release_hold", 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
